fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
Frame controller that sequences the 64-point FFT core. It collects one frame of complex samples over a valid/ready stream into a holding buffer and drives the buffer onto the FFT core's parallel inputs. It then issues a one-cycle start pulse, waits a fixed core latency, captures the core's parallel outputs and streams them out one bin per handshake. It sits between the sample front-end and the FFT core, and is the only block that drives the core's start.

Parameters:
N, 64, points per frame (power of two, matches FFT core)
W, 16, bits per real/imag component (two's complement)
FFT_LATENCY, 150, cycles from the cycle fft_start is high to the cycle the core outputs are valid (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input sample valid
in_ready  out  1  block accepts an input sample
in_re  in  W  input sample real part
in_im  in  W  input sample imag part
fft_start  out  1  one-cycle start pulse to the FFT core
fft_in_re  out  N x W  parallel real inputs to the core (unpacked array [N-1:0])
fft_in_im  out  N x W  parallel imag inputs to the core
fft_out_re  in  N x W  parallel real outputs from the core
fft_out_im  in  N x W  parallel imag outputs from the core
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts the output bin
out_re  out  W  output bin real part
out_im  out  W  output bin imag part
out_last  out  1  high with bin N-1
busy  out  1  high in every state except FILL

Behaviour:
- Reset (rst low, asynchronous): state FILL, wr_idx = rd_idx = 0, wait counter 0, ibuf/obuf all 0, fft_start 0, out_valid 0, out_last 0, out_re/out_im 0, busy 0, in_ready 1 once rst is high.
- FILL: in_ready = 1. On in_valid && in_ready, write ibuf[wr_idx] and increment wr_idx. The handshake with wr_idx == N-1 moves to LAUNCH, and wr_idx wraps to 0. in_valid is ignored in all other states.
- LAUNCH (exactly 1 cycle): fft_start = 1. Load the wait counter with FFT_LATENCY-1. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reads 0, latch fft_out_re/fft_out_im into obuf and go to DRAIN.
- Timing: fft_start high in cycle c means obuf is captured at the end of cycle c+FFT_LATENCY, and out_valid is first high in cycle c+FFT_LATENCY+1.
- DRAIN: out_valid = 1, out_re/out_im = obuf[rd_idx], out_last = (rd_idx == N-1). On out_valid && out_ready, increment rd_idx. The handshake with rd_idx == N-1 goes to FILL and clears rd_idx. While stalled (!out_ready), the payload and out_last hold stable.
- fft_in_re/fft_in_im are wired from ibuf and are held constant from LAUNCH through the end of DRAIN. ibuf is overwritten only in FILL.
- in_ready is 0 from the cycle after the Nth accept until the last DRAIN handshake, so frames never overlap. Maximum throughput is 1 frame per N + 1 + FFT_LATENCY + N cycles.
- out_re/out_im are 0 whenever out_valid is 0.
- Reset mid-frame (any state): immediate return to FILL. Partially filled or drained data is discarded and no stray fft_start is produced.
- Counters are sized $clog2(N) and $clog2(FFT_LATENCY+1). No arithmetic on data except under the optional feature.

Optional Feature:
FFT_SCHED_IFFT_EN
- Defined: adds input port ifft (1 bit), sampled on the first FILL handshake of a frame and held for the whole frame. When set, in_im is negated on write to ibuf and obuf imag is negated on output (the conjugation identity gives the IFFT without scaling). Negating -2^(W-1) saturates to 2^(W-1)-1.
- Undefined: no ifft port, and data passes through unmodified.

Test Plan:
- Reset -> all outputs 0, in_ready = 1, busy = 0; asserting rst low again mid-DRAIN -> out_valid drops in the same cycle (async), and the next frame behaves normally.
- 64 samples, in_valid held high, re = 4 for i < 32 and 0 otherwise, im = 0 -> exactly one fft_start pulse, in the cycle after the 64th accept; fft_in_re[0..31] = 4 and fft_in_re[32..63] = 0; in_ready low until drain ends.
- Stub core driving fft_out_re[k] = k, fft_out_im[k] = -k, FFT_LATENCY = 5, out_ready = 1 -> out_valid first high 6 cycles after fft_start; bins stream 0..63 with im 0..-63; out_last only on bin 63.
- out_ready toggling 1,0,1,0 -> no bin skipped or duplicated; payload stable during each stall; 64 handshakes total.
- in_valid at 50% duty -> wr_idx advances only on handshakes; fft_start only after exactly 64 accepts.
- FFT_SCHED_IFFT_EN with ifft = 1, in_im = -32768 and stub core passing data through -> stored im = 32767; output im = -32767.

Source files
------------

// File: rtl/fft_frame_sched.sv
// -----------------------------------------------------------------------------
// fft_frame_sched
// Frame controller for an N-point FFT core. It collects one frame of complex
// samples into a holding buffer (ibuf) that drives the core's parallel inputs.
// It then pulses fft_start, waits FFT_LATENCY cycles and captures the core's
// parallel outputs into obuf. The bins are then streamed out one per handshake.
//
// Optional feature macro: FFT_SCHED_IFFT_EN
//   Adds the 'ifft' input. When it is set for a frame, the imaginary part of
//   each input sample is negated with saturation on write, and the imaginary
//   part of each output bin is negated on read. By the conjugation identity
//   this gives an unscaled IFFT.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input sample handshake; in_re/in_im sample payload
//   fft_start            one-cycle start pulse to the FFT core
//   fft_in_re/fft_in_im  parallel core inputs, driven from ibuf
//   fft_out_re/_im       parallel core outputs, captured into obuf
//   out_valid/out_ready  output bin handshake; out_re/out_im bin payload
//   out_last             high together with bin N-1
//   busy                 high in every state except FILL
//   ifft                 (FFT_SCHED_IFFT_EN only) frame-wide IFFT select
// -----------------------------------------------------------------------------
module fft_frame_sched #(
   parameter int N           = 64,
   parameter int W           = 16,
   parameter int FFT_LATENCY = 150
) (
   input  logic         clk,
   input  logic         rst,
`ifdef FFT_SCHED_IFFT_EN
   input  logic         ifft,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic         fft_start,
   output logic [W-1:0] fft_in_re  [N-1:0],
   output logic [W-1:0] fft_in_im  [N-1:0],
   input  logic [W-1:0] fft_out_re [N-1:0],
   input  logic [W-1:0] fft_out_im [N-1:0],
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_last,
   output logic         busy
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(FFT_LATENCY + 1);

   typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [CW-1:0] wait_cnt;
   logic [W-1:0]  ibuf_re [N-1:0];
   logic [W-1:0]  ibuf_im [N-1:0];
   logic [W-1:0]  obuf_re [N-1:0];
   logic [W-1:0]  obuf_im [N-1:0];
   logic          in_fire, out_fire, wr_last, rd_last, wait_done;
   logic [W-1:0]  in_im_w, obuf_im_rd;

   assign wr_last   = (wr_idx == IW'(N - 1));
   assign rd_last   = (rd_idx == IW'(N - 1));
   assign wait_done = (state == WAIT) && (wait_cnt == '0);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // The core sees ibuf directly. Because ibuf is written only in FILL, the
   // core inputs stay constant from LAUNCH through the end of DRAIN.
   assign fft_in_re = ibuf_re;
   assign fft_in_im = ibuf_im;

`ifdef FFT_SCHED_IFFT_EN
   logic ifft_q, ifft_cur;

   // Negating the most negative value would overflow, so saturate it instead.
   function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
      if (v == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
      return -v;
   endfunction

   // The first accept of a frame uses the live port value. Every later accept
   // uses the value registered on that first accept.
   assign ifft_cur   = (wr_idx == '0) ? ifft : ifft_q;
   assign in_im_w    = ifft_cur ? neg_sat(in_im) : in_im;
   assign obuf_im_rd = ifft_q ? neg_sat(obuf_im[rd_idx]) : obuf_im[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       ifft_q <= 1'b0;
      else if (in_fire && wr_idx == '0) ifft_q <= ifft;
   end
`else
   assign in_im_w    = in_im;
   assign obuf_im_rd = obuf_im[rd_idx];
`endif

   // NOTE: sequential state is updated with <= so that every flop samples the
   // pre-edge values, independent of the order in which the processes run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FILL;
      else      state <= state_nxt;
   end

   // NOTE: every output and next-state signal gets a default first. A path
   // through the case that leaves a signal unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      fft_start = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_re    = '0;
      out_im    = '0;
      busy      = 1'b1;
      unique case (state)
         FILL: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid && wr_last) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            fft_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == '0) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_re    = obuf_re[rd_idx];
            out_im    = obuf_im_rd;
            out_last  = rd_last;
            if (out_ready && rd_last) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // NOTE: the frame buffers are reset explicitly. This guarantees that the
   // core inputs and the output payload read as zero after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_idx   <= '0;
         rd_idx   <= '0;
         wait_cnt <= '0;
         for (int i = 0; i < N; i++) begin
            ibuf_re[i] <= '0;
            ibuf_im[i] <= '0;
            obuf_re[i] <= '0;
            obuf_im[i] <= '0;
         end
      end else begin
         // N is a power of two, so wr_idx wraps to 0 after the last sample.
         if (in_fire) begin
            ibuf_re[wr_idx] <= in_re;
            ibuf_im[wr_idx] <= in_im_w;
            wr_idx          <= wr_idx + 1'b1;
         end
         // Loading LATENCY-1 at LAUNCH makes the count reach zero exactly
         // FFT_LATENCY cycles after the start pulse.
         if (state == LAUNCH)
            wait_cnt <= CW'(FFT_LATENCY - 1);
         else if (state == WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;
         if (wait_done) begin
            for (int i = 0; i < N; i++) begin
               obuf_re[i] <= fft_out_re[i];
               obuf_im[i] <= fft_out_im[i];
            end
         end
         if (out_fire) rd_idx <= rd_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sched
// Self-checking bench for fft_frame_sched, built with FFT_LATENCY = 5.
// A stub core presents its outputs only in the single cycle in which the
// scheduler is meant to capture them, and drives junk in every other cycle.
// Stub modes:
//   0: ramp, bin k = (k, -k)
//   1: reversal, bin k = input sample N-1-k
// Expected values come from a frame-level model: the list of samples that
// were accepted, plus the conjugation rule when FFT_SCHED_IFFT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fft_frame_sched;

   localparam int N   = 64;
   localparam int W   = 16;
   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid, in_ready, fft_start;
   logic [W-1:0] in_re, in_im;
   logic [W-1:0] fft_in_re  [N-1:0];
   logic [W-1:0] fft_in_im  [N-1:0];
   logic [W-1:0] fft_out_re [N-1:0];
   logic [W-1:0] fft_out_im [N-1:0];
   logic         out_valid, out_ready, out_last, busy;
   logic [W-1:0] out_re, out_im;
`ifdef FFT_SCHED_IFFT_EN
   logic         ifft;
`endif

   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_starts = 0;
   int           age;
   int           stub_mode = 0;
   bit           frame_ifft = 1'b0;
   logic [W-1:0] m_in_re [N];
   logic [W-1:0] m_in_im [N];

   always #5 clk = ~clk;

   fft_frame_sched #(.N(N), .W(W), .FFT_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
`ifdef FFT_SCHED_IFFT_EN
      .ifft(ifft),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .fft_start(fft_start), .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
      .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
      .out_im(out_im), .out_last(out_last), .busy(busy)
   );

   // age = number of cycles since the cycle in which fft_start was high.
   always @(posedge clk or negedge rst) begin
      if (!rst)          age <= 0;
      else if (fft_start) age <= 1;
      else if (age != 0)  age <= age + 1;
   end

   always @(posedge clk) if (fft_start === 1'b1) n_starts++;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         fft_out_re[k] = 16'hDEAD;
         fft_out_im[k] = 16'hBEEF;
         if (age == LAT) begin
            if (stub_mode == 0) begin
               fft_out_re[k] = W'(k);
               fft_out_im[k] = W'(-k);
            end else begin
               fft_out_re[k] = fft_in_re[N-1-k];
               fft_out_im[k] = fft_in_im[N-1-k];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] conj_im(input logic [W-1:0] v);
      if (v == 16'h8000) return 16'h7FFF;
      return W'(-v);
   endfunction

   function automatic logic [W-1:0] exp_re(input int k);
      return (stub_mode == 0) ? W'(k) : m_in_re[N-1-k];
   endfunction

   function automatic logic [W-1:0] exp_im(input int k);
      logic [W-1:0] core;
      core = (stub_mode == 0) ? W'(-k) : m_in_im[N-1-k];
      return frame_ifft ? conj_im(core) : core;
   endfunction

   function automatic bit fin_match(input bit zero);
      bit ok = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (fft_in_re[k] !== (zero ? '0 : m_in_re[k])) ok = 1'b0;
         if (fft_in_im[k] !== (zero ? '0 : m_in_im[k])) ok = 1'b0;
      end
      return ok;
   endfunction

   // kind 0: re = 4 for i < 32, else 0, im = 0
   // kind 1: random data
   // kind 2: random data with im forced to -32768 on every 8th sample
   task automatic send_frame(input int kind, input int duty, input bit ifft_v);
      int           sent = 0;
      int           guard = 0;
      logic [W-1:0] re, im;
      frame_ifft = ifft_v;
      while (sent < N && guard < 5000) begin
         @(negedge clk);
         guard++;
         check("fill_in_ready", in_ready, 1);
         if (int'($urandom_range(99)) < duty) begin
            re = (kind == 0) ? ((sent < 32) ? W'(4) : '0) : W'($urandom);
            im = (kind == 0) ? '0 : W'($urandom);
            if (kind == 2 && sent % 8 == 0) im = 16'h8000;
`ifdef FFT_SCHED_IFFT_EN
            // Only the first accept may set the frame's mode.
            ifft = (sent == 0) ? ifft_v : ~ifft_v;
`endif
            in_valid = 1'b1;
            in_re    = re;
            in_im    = im;
            m_in_re[sent] = re;
            m_in_im[sent] = ifft_v ? conj_im(im) : im;
            sent++;
         end else begin
            in_valid = 1'b0;
            in_re    = W'($urandom);
            in_im    = W'($urandom);
         end
      end
      if (guard >= 5000) check("fill_timeout", 0, 1);
   endtask

   task automatic launch_and_wait(input int start_base);
      int waited = 0;
      @(negedge clk);
      // Junk on the input port must be ignored until the frame has drained.
      in_valid = 1'b1;
      in_re    = W'($urandom);
      in_im    = W'($urandom);
      check("launch_fft_start", fft_start, 1);
      check("launch_in_ready", in_ready, 0);
      check("launch_busy", busy, 1);
      check("launch_fft_in", fin_match(1'b0), 1);
      while (out_valid !== 1'b1 && waited < 1000) begin
         @(negedge clk);
         waited++;
         if (out_valid !== 1'b1) check("wait_in_ready", in_ready, 0);
      end
      check("out_valid_latency", waited, LAT + 1);
      check("start_count", n_starts, start_base + 1);
   endtask

   // rmode 0: out_ready always 1; 1: toggle 1,0,1,0; 2: random.
   // If reset_at >= 0, rst is asserted once reset_at bins have been taken.
   task automatic drain(input int rmode, input int reset_at);
      int got = 0;
      int guard = 0;
      bit tgl = 1'b1;
      int base;
      while (got < N && guard < 5000) begin
         if (got == reset_at) begin
            base = n_starts;
            #2 rst = 1'b0;
            #1;
            check("async_rst_out_valid", out_valid, 0);
            check("async_rst_out_re", out_re, 0);
            check("async_rst_busy", busy, 0);
            check("async_rst_in_ready", in_ready, 1);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            check("rst_fft_in_zero", fin_match(1'b1), 1);
            rst = 1'b1;
            repeat (LAT + 3) @(negedge clk);
            check("rst_no_stray_start", n_starts, base);
            return;
         end
         out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tgl : 1'($urandom_range(1));
         tgl = ~tgl;
         check("drain_valid", out_valid, 1);
         check("drain_re", out_re, exp_re(got));
         check("drain_im", out_im, exp_im(got));
         check("drain_last", out_last, (got == N - 1) ? 1 : 0);
         check("drain_in_ready", in_ready, 0);
         if (got == N - 1 && out_ready) check("drain_fft_in_held", fin_match(1'b0), 1);
         if (out_ready) got++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) check("drain_timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_out_re", out_re, 0);
      check("post_out_im", out_im, 0);
      check("post_out_last", out_last, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      out_ready = 1'b0;
`ifdef FFT_SCHED_IFFT_EN
      ifft = 1'b0;
`endif
      rst = 1'b0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_fft_start", fft_start, 0);
      check("rst_busy", busy, 0);
      check("rst_out_re", out_re, 0);
      check("rst_out_last", out_last, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rel_in_ready", in_ready, 1);
      check("rel_out_im", out_im, 0);
      check("rel_fft_in_zero", fin_match(1'b1), 1);

      // Directed step frame into a ramp core, with full throughput.
      stub_mode = 0;
      send_frame(0, 100, 1'b0);
      launch_and_wait(n_starts);
      drain(0, -1);

      // Random data at a 50% input duty cycle into the reversal core,
      // drained with out_ready toggling 1,0,1,0.
      stub_mode = 1;
      send_frame(1, 50, 1'b0);
      launch_and_wait(n_starts);
      drain(1, -1);

      // Reset in the middle of DRAIN.
      send_frame(1, 70, 1'b0);
      launch_and_wait(n_starts);
      drain(2, 20);

      // Next frame after the reset, with random backpressure.
      send_frame(1, 100, 1'b0);
      launch_and_wait(n_starts);
      drain(2, -1);

`ifdef FFT_SCHED_IFFT_EN
      send_frame(2, 100, 1'b1);
      launch_and_wait(n_starts);
      check("ifft_sat_stored", fft_in_im[0], 16'h7FFF);
      drain(0, -1);
      send_frame(2, 80, 1'b0);
      launch_and_wait(n_starts);
      check("fft_raw_stored", fft_in_im[0], 16'h8000);
      drain(2, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
